// File: rtl/sprite_pipe_mapper.sv
// Pipelined per-player sprite renderer: maps hcount/vcount to a shared multi-frame BRAM address
// and realigns the returned pixel. Optional hit-flash overlay enabled by macro SPRITE_FLASH_EN.
module sprite_pipe_mapper #(
  parameter int unsigned SPR_W        = 126,
  parameter int unsigned SPR_H        = 126,
  parameter int unsigned NUM_FRAMES   = 36,
  parameter int unsigned FRAME_BITS   = 6,
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned ROM_LAT      = 1,
  parameter logic [11:0] KEY_RGB      = 12'h000,
  parameter logic [11:0] FLASH_RGB    = 12'hFFF,
  parameter int unsigned FLASH_FRAMES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            hcount,
  input  logic [9:0]            vcount,
  input  logic                  frame_strobe,
  input  logic [9:0]            pos_x,
  input  logic [9:0]            pos_y,
  input  logic                  facing_right,
  input  logic [FRAME_BITS-1:0] frame_idx,
  input  logic                  hit_pulse,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [11:0]           rom_data,
  output logic                  sprite_on,
  output logic [11:0]           sprite_rgb
);

  localparam int unsigned FRAME_SZ = SPR_W * SPR_H;
  localparam int unsigned DLY      = ROM_LAT + 1;

  logic [9:0]            px_r, py_r;
  logic                  facing_r;
  logic [FRAME_BITS-1:0] fidx_r;
  logic                  armed_r;
  logic [FRAME_BITS-1:0] fidx_sel_s;

  logic                  inside_s;
  logic [9:0]            row_s, col_s, diff_h_s;
  logic                  inside_s0_r;
  logic [9:0]            row_r, col_r;
  logic [FRAME_BITS-1:0] fidx_s0_r;
  logic [ADDR_W-1:0]     addr_s;
  logic [DLY-1:0]        inside_sr_r;

  logic                  flash_s;
  logic                  on_s;
  logic [11:0]           rgb_s;

  // Out-of-range frame numbers fall back to frame 0
  always_comb begin
    fidx_sel_s = frame_idx;
    if (32'(frame_idx) >= NUM_FRAMES) begin
      fidx_sel_s = {FRAME_BITS{1'b0}};
    end else begin
      fidx_sel_s = frame_idx;
    end
  end

  // Shadow pose: captured only at frame_strobe so a sprite never tears mid-scan
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_r     <= 10'd0;
      py_r     <= 10'd0;
      facing_r <= 1'b0;
      fidx_r   <= {FRAME_BITS{1'b0}};
      armed_r  <= 1'b0;
    end else if (frame_strobe) begin
      px_r     <= pos_x;
      py_r     <= pos_y;
      facing_r <= facing_right;
      fidx_r   <= fidx_sel_s;
      armed_r  <= 1'b1;
    end else begin
      px_r     <= px_r;
      py_r     <= py_r;
      facing_r <= facing_r;
      fidx_r   <= fidx_r;
      armed_r  <= armed_r;
    end
  end

  // Bounding-box test in 11 bits so a sprite past column/row 1023 clips instead of wrapping
  always_comb begin
    inside_s = ({1'b0, hcount} >= {1'b0, px_r}) &&
               ({1'b0, hcount} <  ({1'b0, px_r} + 11'(SPR_W))) &&
               ({1'b0, vcount} >= {1'b0, py_r}) &&
               ({1'b0, vcount} <  ({1'b0, py_r} + 11'(SPR_H)));
    diff_h_s = hcount - px_r;
    row_s    = vcount - py_r;
    if (facing_r) begin
      col_s = diff_h_s;
    end else begin
      col_s = 10'(SPR_W - 1) - diff_h_s;
    end
  end

  // Stage S0: register hit test, sprite-local coordinates and the frame they belong to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inside_s0_r <= 1'b0;
      row_r       <= 10'd0;
      col_r       <= 10'd0;
      fidx_s0_r   <= {FRAME_BITS{1'b0}};
    end else begin
      inside_s0_r <= inside_s;
      row_r       <= row_s;
      col_r       <= col_s;
      fidx_s0_r   <= fidx_r;
    end
  end

  // Linear address into the back-to-back frame store
  always_comb begin
    addr_s = ADDR_W'(fidx_s0_r) * ADDR_W'(FRAME_SZ) +
             ADDR_W'(row_r) * ADDR_W'(SPR_W) + ADDR_W'(col_r);
  end

  // Stage S1: address register holds its last value outside the sprite
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= {ADDR_W{1'b0}};
    end else if (inside_s0_r) begin
      rom_addr <= addr_s;
    end else begin
      rom_addr <= rom_addr;
    end
  end

  // Delay the hit flag so it lines up with the BRAM data return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inside_sr_r <= {DLY{1'b0}};
    end else begin
      inside_sr_r <= {inside_sr_r[DLY-2:0], inside_s0_r};
    end
  end

`ifdef SPRITE_FLASH_EN
  localparam int unsigned FC_W = ($clog2(FLASH_FRAMES + 1) < 2) ? 2 : $clog2(FLASH_FRAMES + 1);
  logic [FC_W-1:0] flash_cnt_r;

  // Hit-flash countdown in video frames; a new hit always reloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_cnt_r <= {FC_W{1'b0}};
    end else if (hit_pulse) begin
      flash_cnt_r <= FC_W'(FLASH_FRAMES);
    end else if (frame_strobe && (flash_cnt_r != {FC_W{1'b0}})) begin
      flash_cnt_r <= flash_cnt_r - {{(FC_W-1){1'b0}}, 1'b1};
    end else begin
      flash_cnt_r <= flash_cnt_r;
    end
  end

  assign flash_s = (flash_cnt_r != {FC_W{1'b0}}) && flash_cnt_r[1];
`else
  logic flash_unused_s;
  assign flash_unused_s = hit_pulse | (FLASH_FRAMES == 32'd0);
  assign flash_s        = 1'b0;
`endif

  // Output colour select: transparent key, flash overlay, or BRAM pixel
  always_comb begin
    on_s  = inside_sr_r[DLY-1] && armed_r && (rom_data != KEY_RGB);
    rgb_s = 12'h000;
    if (on_s) begin
      if (flash_s) begin
        rgb_s = FLASH_RGB;
      end else begin
        rgb_s = rom_data;
      end
    end else begin
      rgb_s = 12'h000;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sprite_on  <= 1'b0;
      sprite_rgb <= 12'h000;
    end else begin
      sprite_on  <= on_s;
      sprite_rgb <= rgb_s;
    end
  end

endmodule

// File: tb/tb_sprite_pipe_mapper.sv
// Scoreboard bench for sprite_pipe_mapper (default parameters, ROM_LAT=1) with a behavioural BRAM.
module tb_sprite_pipe_mapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        frame_strobe;
  logic [9:0]  pos_x, pos_y;
  logic        facing_right;
  logic [5:0]  frame_idx;
  logic        hit_pulse;
  logic [19:0] rom_addr;
  logic [11:0] rom_data = 12'h000;
  logic        sprite_on;
  logic [11:0] sprite_rgb;

  always #5 clk = ~clk;

  sprite_pipe_mapper dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .frame_strobe(frame_strobe), .pos_x(pos_x), .pos_y(pos_y),
    .facing_right(facing_right), .frame_idx(frame_idx), .hit_pulse(hit_pulse),
    .rom_addr(rom_addr), .rom_data(rom_data), .sprite_on(sprite_on), .sprite_rgb(sprite_rgb)
  );

  typedef struct { int due; logic on; logic [11:0] rgb; } out_exp_t;
  typedef struct { int due; logic [19:0] addr; } addr_exp_t;
  out_exp_t  out_q[$];
  addr_exp_t addr_q[$];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic flash_exp = 1'b0;

  // Sprite BRAM contents: every address with addr%7==3 holds the transparent key
  function automatic logic [11:0] rom_fn(input logic [19:0] a);
    if (a % 20'd7 == 20'd3) return 12'h000;
    return {a[10:0], 1'b1} ^ 12'h300;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs against queued expectations when they fall due
  always @(negedge clk) begin
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      addr_exp_t a;
      a = addr_q.pop_front();
      chk("rom_addr", 32'(rom_addr), 32'(a.addr));
    end
    while (out_q.size() > 0 && out_q[0].due <= cyc) begin
      out_exp_t o;
      o = out_q.pop_front();
      chk("sprite_on", 32'(sprite_on), 32'(o.on));
      chk("sprite_rgb", 32'(sprite_rgb), 32'(o.rgb));
    end
  end

  // One pixel per clock; expectation for rom_addr at +2, outputs at +4
  task automatic pix(input int h, input int v, input logic strobe,
                     input logic chk_a, input int exp_addr, input logic exp_on);
    logic [11:0] rgb;
    @(negedge clk);
    hcount = 10'(h);
    vcount = 10'(v);
    frame_strobe = strobe;
    if (!exp_on) rgb = 12'h000;
    else if (flash_exp) rgb = 12'hFFF;
    else rgb = rom_fn(20'(exp_addr));
    if (chk_a) addr_q.push_back('{due: cyc + 2, addr: 20'(exp_addr)});
    out_q.push_back('{due: cyc + 4, on: exp_on, rgb: rgb});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(500, 500, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_sprite_on", 32'(sprite_on), 32'd0);
    chk("rst_sprite_rgb", 32'(sprite_rgb), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
  endtask

  initial begin
    logic [17:0] fl_mask;
    fl_mask = 18'b00_0110_0110_0110_0110;
    rst_n = 1'b0; hcount = 10'd0; vcount = 10'd0; frame_strobe = 1'b0;
    pos_x = 10'd0; pos_y = 10'd0; facing_right = 1'b0; frame_idx = 6'd0; hit_pulse = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;

    // Not armed yet: zero shadow pose is mirrored at (0,0), (5,5) -> col 120 -> 750
    pix(5, 5, 1'b0, 1'b1, 750, 1'b0);
    idle(4);

    // Test 1: pose 100,50 right frame 0; strobe-cycle pixel still uses old pose
    pos_x = 10'd100; pos_y = 10'd50; facing_right = 1'b1; frame_idx = 6'd0;
    pix(0, 0, 1'b1, 1'b1, 125, 1'b1);
    pix(100, 50, 1'b0, 1'b1, 0, 1'b1);
    pix(103, 50, 1'b0, 1'b1, 3, 1'b0);
    pix(99, 50, 1'b0, 1'b0, 0, 1'b0);
    pix(100, 49, 1'b0, 1'b0, 0, 1'b0);
    pix(225, 50, 1'b0, 1'b1, 125, 1'b1);
    pix(226, 50, 1'b0, 1'b1, 125, 1'b0);
`ifndef SPRITE_FLASH_EN
    hit_pulse = 1'b1;
    pix(100, 50, 1'b0, 1'b1, 0, 1'b1);
    hit_pulse = 1'b0;
`endif

    // Test 2: frame 2 bottom-right corner
    frame_idx = 6'd2;
    pix(300, 300, 1'b1, 1'b0, 0, 1'b0);
    pix(225, 175, 1'b0, 1'b1, 47627, 1'b1);
    pix(225, 176, 1'b0, 1'b0, 0, 1'b0);

    // Test 3: mirrored; facing change without strobe is ignored
    facing_right = 1'b0; frame_idx = 6'd0;
    pix(300, 300, 1'b1, 1'b0, 0, 1'b0);
    pix(100, 50, 1'b0, 1'b1, 125, 1'b1);
    pix(225, 50, 1'b0, 1'b1, 0, 1'b1);
    facing_right = 1'b1;
    pix(100, 50, 1'b0, 1'b1, 125, 1'b1);
    pix(300, 300, 1'b1, 1'b0, 0, 1'b0);
    pix(100, 50, 1'b0, 1'b1, 0, 1'b1);

    // Test 4: out-of-range frame -> 0; right-edge clip without wrap
    frame_idx = 6'd40; pos_x = 10'd950;
    pix(300, 300, 1'b1, 1'b0, 0, 1'b0);
    pix(950, 50, 1'b0, 1'b1, 0, 1'b1);
    pix(1022, 50, 1'b0, 1'b1, 72, 1'b1);
    pix(1023, 50, 1'b0, 1'b1, 73, 1'b0);
    pix(0, 50, 1'b0, 1'b0, 0, 1'b0);
    pix(51, 50, 1'b0, 1'b1, 73, 1'b0);

    // Test 5: reset mid-line with pixels in flight
    pix(950, 50, 1'b0, 1'b0, 0, 1'b1);
    pix(960, 50, 1'b0, 1'b0, 0, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    out_q.delete();
    addr_q.delete();
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    pix(5, 5, 1'b0, 1'b1, 750, 1'b0);
    pix(950, 50, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    pos_x = 10'd100; frame_idx = 6'd0;
    pix(0, 0, 1'b1, 1'b1, 125, 1'b1);
    pix(100, 50, 1'b0, 1'b1, 0, 1'b1);

`ifdef SPRITE_FLASH_EN
    // Test 6: hit flash over 17 frames
    pix(300, 300, 1'b0, 1'b0, 0, 1'b0);
    hit_pulse = 1'b1;
    pix(300, 300, 1'b0, 1'b0, 0, 1'b0);
    hit_pulse = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      pix(300, 300, 1'b1, 1'b0, 0, 1'b0);
      flash_exp = fl_mask[k];
      pix(100, 50, 1'b0, 1'b1, 0, 1'b1);
      flash_exp = 1'b0;
    end
`endif

    idle(1);
    for (int i = 0; i < 20 && (out_q.size() > 0 || addr_q.size() > 0); i++) @(negedge clk);
    #1;
    chk("drain_pending", 32'(out_q.size() + addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
